// File: rtl/wr_fram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wr_fram_pkg
// Brief    : Shared widths, lane count and burst FSM encoding for wr_fram_pack.
// Revision : 1.0 - initial release
// ============================================================================
package wr_fram_pkg;

    localparam int c_PIX_W  = 32;
    localparam int c_WORD_W = 256;
    localparam int c_LANES  = 8;
    localparam int c_LANE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } burst_state_t;

endpackage
`default_nettype wire

// File: rtl/wr_fram_ram.sv
`default_nettype none
// ============================================================================
// Module   : wr_fram_ram
// Brief    : Single-clock simple dual-port RAM with a registered, resettable
//            read port that holds its value when no read is issued.
// Revision : 1.0 - initial release
// ============================================================================
module wr_fram_ram
    import wr_fram_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = c_WORD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/wr_fram_pack.sv
`default_nettype none
// ============================================================================
// Module   : wr_fram_pack
// Brief    : Packs 32-bit pixels into 256-bit words, buffers them in a FIFO
//            and hands them to the DDR side in BURST_LEN-word bursts.
//            Optional macro WR_FRAM_OVF_CNT_EN adds a saturating ovf_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module wr_fram_pack
    import wr_fram_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int FIFO_AW   = 9
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    input  logic                frame_start,
    input  logic                pix_vld,
    input  logic [c_PIX_W-1:0]  pix_data,
    output logic                burst_req,
    input  logic                burst_ack,
    input  logic                ddr_rd_en,
    output logic [c_WORD_W-1:0] ddr_rd_data,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                ovf
`ifdef WR_FRAM_OVF_CNT_EN
    ,
    output logic [15:0]         ovf_cnt
`endif
);

    localparam int                c_BEAT_W    = $clog2(BURST_LEN);
    localparam logic [FIFO_AW:0]  c_FULL      = (FIFO_AW+1)'(2**FIFO_AW);
    localparam logic [FIFO_AW:0]  c_BURST_LVL = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN-1);
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_LANES-1);

    // ---------------------------------------------------------------------
    // Pixel packing: lanes 0..6 are staged, lane 7 completes the word
    // ---------------------------------------------------------------------
    logic [c_LANE_W-1:0]               r_lane;
    logic [c_LANES-2:0][c_PIX_W-1:0]   r_pack;
    logic                              r_push;
    logic [c_WORD_W-1:0]               r_push_data;
    logic [c_LANE_W-1:0]               w_lane;

    assign w_lane = frame_start ? '0 : r_lane;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_lane      <= '0;
            r_pack      <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            if (pix_vld) begin
                r_lane <= w_lane + 1'b1;
                if (w_lane == c_LAST_LANE) begin
                    r_push      <= 1'b1;
                    r_push_data <= {pix_data, r_pack};
                end else begin
                    r_pack[w_lane] <= pix_data;
                end
            end else if (frame_start) begin
                r_lane <= '0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Word FIFO bookkeeping
    // ---------------------------------------------------------------------
    burst_state_t          r_state;
    logic [c_BEAT_W-1:0]   r_beat;
    logic                  r_burst_req;
    logic [FIFO_AW-1:0]    r_wr_ptr;
    logic [FIFO_AW-1:0]    r_rd_ptr;
    logic [FIFO_AW:0]      r_level;
    logic                  r_ovf;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_rd_en;

    assign w_full  = (r_level == c_FULL);
    assign w_wr_en = r_push & ~w_full;
    assign w_rd_en = ddr_rd_en & (r_state == ST_XFER);

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (r_push && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef WR_FRAM_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_ovf_cnt <= '0;
        end else if (r_push && w_full && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    // ---------------------------------------------------------------------
    // Burst handshake FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_burst_req <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_level >= c_BURST_LVL) begin
                        r_state     <= ST_REQ;
                        r_burst_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (burst_ack) begin
                        r_state     <= ST_XFER;
                        r_burst_req <= 1'b0;
                        r_beat      <= '0;
                    end
                end
                ST_XFER: begin
                    if (ddr_rd_en) begin
                        if (r_beat == c_LAST_BEAT) begin
                            r_state <= ST_IDLE;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_beat      <= '0;
                    r_burst_req <= 1'b0;
                end
            endcase
        end
    end

    wr_fram_ram #(
        .AW (FIFO_AW),
        .DW (c_WORD_W)
    ) u_ram (
        .clk       (wr_clk),
        .rst       (wr_rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (r_push_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (ddr_rd_data)
    );

    assign burst_req  = r_burst_req;
    assign fifo_level = r_level;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wr_fram_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_wr_fram_pack
// Brief    : Self-checking bench for wr_fram_pack (table vectors + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wr_fram_pack;

    localparam int BL    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic         wr_clk;
    logic         wr_rst;
    logic         frame_start;
    logic         pix_vld;
    logic [31:0]  pix_data;
    logic         burst_req;
    logic         burst_ack;
    logic         ddr_rd_en;
    logic [255:0] ddr_rd_data;
    logic [AW:0]  fifo_level;
    logic         ovf;
`ifdef WR_FRAM_OVF_CNT_EN
    logic [15:0]  ovf_cnt;
`endif

    wr_fram_pack #(
        .BURST_LEN (BL),
        .FIFO_AW   (AW)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .frame_start (frame_start),
        .pix_vld     (pix_vld),
        .pix_data    (pix_data),
        .burst_req   (burst_req),
        .burst_ack   (burst_ack),
        .ddr_rd_en   (ddr_rd_en),
        .ddr_rd_data (ddr_rd_data),
        .fifo_level  (fifo_level),
        .ovf         (ovf)
`ifdef WR_FRAM_OVF_CNT_EN
        ,
        .ovf_cnt     (ovf_cnt)
`endif
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    typedef struct packed {
        logic [7:0][31:0] px;
        logic [9:0]       exp_level;
    } vec_t;

    vec_t         tbl [16];
    logic [255:0] exp_q [$];
    int           n_tests     = 0;
    int           n_fail      = 0;
    int           mdl_level   = 0;
    int           mdl_ovf_cnt = 0;
    logic [255:0] last_word   = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic px(input logic [31:0] d, input logic fs);
        pix_vld     = 1'b1;
        pix_data    = d;
        frame_start = fs;
        step();
        pix_vld     = 1'b0;
        frame_start = 1'b0;
    endtask

    // Model: a complete word lands in the FIFO unless it is already full.
    task automatic push_word(input logic [255:0] w);
        for (int i = 0; i < 8; i++) px(w[i*32 +: 32], 1'b0);
        if (mdl_level == DEPTH) begin
            mdl_ovf_cnt++;
        end else begin
            exp_q.push_back(w);
            mdl_level++;
        end
    endtask

    function automatic logic [255:0] gen_word(input int n);
        logic [255:0] w;
        for (int l = 0; l < 8; l++) w[l*32 +: 32] = (32'(n) * 32'h0001_0003 + 32'(l)) ^ 32'h5A00_0000;
        return w;
    endfunction

    task automatic wait_req(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (burst_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check({name, "_req_seen"}, 256'(ok), 256'd1);
    endtask

    task automatic pop_one(input string name);
        logic [255:0] exp;
        ddr_rd_en = 1'b1;
        step();
        ddr_rd_en = 1'b0;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %h expected <empty queue>", name, ddr_rd_data);
        end else begin
            exp = exp_q.pop_front();
            mdl_level--;
            last_word = exp;
            check(name, ddr_rd_data, exp);
        end
    endtask

    task automatic ack_burst(input string name);
        wait_req(name);
        burst_ack = 1'b1;
        step();
        burst_ack = 1'b0;
        check({name, "_req_drop"}, 256'(burst_req), 256'd0);
    endtask

    task automatic do_burst(input string name);
        ack_burst(name);
        repeat (BL) pop_one(name);
    endtask

    initial begin
        logic [AW:0] lvl_before;
        wr_rst = 1'b1; frame_start = 1'b0; pix_vld = 1'b0; pix_data = '0;
        burst_ack = 1'b0; ddr_rd_en = 1'b0;
        repeat (3) step();
        check("rst_burst_req", 256'(burst_req), 256'd0);
        check("rst_rd_data", ddr_rd_data, 256'd0);
        check("rst_level", 256'(fifo_level), 256'd0);
        check("rst_ovf", 256'(ovf), 256'd0);
        wr_rst = 1'b0;
        step();

        // Vector table: row 0 is the 1..8 ramp, the rest are varied words.
        for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < 8; l++) begin
                tbl[k].px[l] = (k == 0) ? 32'(l + 1) : (32'(k) << 24) ^ (32'h0101_0101 * 32'(l + 3)) ^ 32'(k * l);
            end
            tbl[k].exp_level = 10'(k + 1);
        end
        for (int k = 0; k < 16; k++) begin
            push_word(tbl[k].px);
            step();
            check("tbl_level", 256'(fifo_level), 256'(tbl[k].exp_level));
        end
        step();
        check("req_high", 256'(burst_req), 256'd1);
        repeat (3) step();
        check("req_hold", 256'(burst_req), 256'd1);

        ack_burst("burst1");
        pop_one("burst1");
        check("ramp_word", ddr_rd_data,
              256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        repeat (BL - 1) pop_one("burst1");
        step();
        check("post_burst_level", 256'(fifo_level), 256'd0);
        repeat (3) step();
        check("post_burst_req", 256'(burst_req), 256'd0);

        ddr_rd_en = 1'b1;
        step();
        ddr_rd_en = 1'b0;
        check("idle_rd_hold", ddr_rd_data, last_word);
        check("idle_rd_level", 256'(fifo_level), 256'd0);

        // Partial word discarded by a lone frame_start.
        for (int i = 0; i < 5; i++) px(32'hDEAD_0000 + 32'(i), 1'b0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        push_word(gen_word(7));
        step();
        check("fs_level", 256'(fifo_level), 256'(mdl_level));

        // frame_start with pix_vld: that pixel is lane 0 of the new word.
        begin
            logic [255:0] w;
            w = gen_word(8);
            for (int i = 0; i < 3; i++) px(32'hBEEF_0000 + 32'(i), 1'b0);
            px(w[31:0], 1'b1);
            for (int i = 1; i < 8; i++) px(w[i*32 +: 32], 1'b0);
            exp_q.push_back(w);
            mdl_level++;
        end
        step();
        check("fs_same_level", 256'(fifo_level), 256'd2);
        burst_ack = 1'b1;
        step();
        burst_ack = 1'b0;
        check("ack_in_idle", 256'(burst_req), 256'd0);

        for (int n = 0; n < DEPTH - 2; n++) push_word(gen_word(1000 + n));
        step();
        check("full_level", 256'(fifo_level), 256'(DEPTH));
        check("full_no_ovf", 256'(ovf), 256'd0);
        push_word(gen_word(9999));
        step();
        check("ovf_level", 256'(fifo_level), 256'(DEPTH));
        check("ovf_flag", 256'(ovf), 256'd1);
`ifdef WR_FRAM_OVF_CNT_EN
        check("ovf_cnt", 256'(ovf_cnt), 256'(mdl_ovf_cnt));
`endif

        do_burst("drain_full");

        // Push and pop landing on the same edge inside a burst.
        ack_burst("simul");
        repeat (4) pop_one("simul");
        push_word(gen_word(4242));
        lvl_before = fifo_level;
        check("simul_pre_level", 256'(lvl_before), 256'(mdl_level - 1));
        pop_one("simul");
        check("simul_level", 256'(fifo_level), 256'(lvl_before));
        repeat (BL - 5) pop_one("simul");

        while (mdl_level >= BL) do_burst("drain_wrap");
        step();
        check("drain_level", 256'(fifo_level), 256'(mdl_level));

        // Reset in the middle of a transfer.
        for (int n = 0; n < BL; n++) push_word(gen_word(5000 + n));
        ack_burst("rst_mid");
        repeat (3) pop_one("rst_mid");
        wr_rst = 1'b1;
        step();
        check("midrst_req", 256'(burst_req), 256'd0);
        check("midrst_data", ddr_rd_data, 256'd0);
        check("midrst_level", 256'(fifo_level), 256'd0);
        check("midrst_ovf", 256'(ovf), 256'd0);
`ifdef WR_FRAM_OVF_CNT_EN
        check("midrst_ovf_cnt", 256'(ovf_cnt), 256'd0);
`endif
        wr_rst = 1'b0;
        exp_q.delete();
        mdl_level = 0;
        step();
        ddr_rd_en = 1'b1;
        step();
        ddr_rd_en = 1'b0;
        check("postrst_rd_ignored", ddr_rd_data, 256'd0);
        check("postrst_level", 256'(fifo_level), 256'd0);
        push_word(gen_word(77));
        step();
        check("postrst_push", 256'(fifo_level), 256'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
